// File: rtl/axis_bram_adapter_v1_0_sched.sv
// axis_bram_adapter_v1_0_sched: round-robin two-requester scheduler for the adapter BRAM port (optional watchdog: AXIS_BRAM_SCHED_TIMEOUT_EN)
module axis_bram_adapter_v1_0_sched #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_rw,
  input  logic [ADDR_W-1:0] a_req_index,
  input  logic [ADDR_W-1:0] a_req_end,
  output logic              a_done,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_rw,
  input  logic [ADDR_W-1:0] b_req_index,
  input  logic [ADDR_W-1:0] b_req_end,
  output logic              b_done,
  output logic              cntl_rw,
  output logic [ADDR_W-1:0] cntl_index,
  output logic [ADDR_W-1:0] cntl_size,
  output logic              cntl_en,
  input  logic              bram_beat,
  output logic              busy,
  output logic              done_err
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [ADDR_W:0] ONE = 1;
  state_t state_q, state_d;
  logic rr_q, rr_d, owner_q, owner_d, rw_q, rw_d;
  logic [ADDR_W-1:0] idx_q, idx_d, size_q, size_d, diff;
  logic [ADDR_W:0] len_q, len_d, cnt_q, cnt_d;
  logic en_q, en_d, busy_q, busy_d, a_done_q, a_done_d, b_done_q, b_done_d, err_q, err_d;
  logic grant_a, grant_b, grant, last_beat, abort;

  // rr_q = 1 means B has priority on a tie; grants only while idle and out of reset
  assign grant_a = rstn && state_q == IDLE && a_req_valid && (!b_req_valid || !rr_q);
  assign grant_b = rstn && state_q == IDLE && b_req_valid && (!a_req_valid || rr_q);
  assign grant = grant_a || grant_b;
  assign diff = grant_b ? b_req_end - b_req_index : a_req_end - a_req_index;
  assign last_beat = state_q == RUN && bram_beat && cnt_q + ONE == len_q;

`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_ONE = 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  logic [WD_W-1:0] wd_q, wd_d;
  assign abort = state_q == RUN && !bram_beat && wd_q + WD_ONE == WD_MAX;
  // watchdog counts consecutive beat-less RUN cycles, zero everywhere else
  always_comb wd_d = (state_q == RUN && !bram_beat) ? wd_q + WD_ONE : '0;
  // watchdog register
  always_ff @(posedge clk) wd_q <= !rstn ? '0 : wd_d;
`else
  assign abort = 1'b0 & (TIMEOUT == 0);
`endif

  // next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant ? LOAD : IDLE;
      LOAD:    state_d = RUN;
      RUN:     state_d = (last_beat || abort) ? DONE : RUN;
      default: state_d = IDLE;
    endcase
    rr_d     = (grant_a && b_req_valid) ? 1'b1 : (grant_b && a_req_valid) ? 1'b0 : rr_q;
    owner_d  = grant ? grant_b : owner_q;
    rw_d     = grant_a ? a_req_rw : grant_b ? b_req_rw : rw_q;
    idx_d    = grant_a ? a_req_index : grant_b ? b_req_index : idx_q;
    size_d   = grant_a ? a_req_end : grant_b ? b_req_end : size_q;
    len_d    = grant ? {1'b0, diff} + ONE : len_q;
    cnt_d    = state_q != RUN ? '0 : bram_beat ? cnt_q + ONE : cnt_q;
    en_d     = state_d == RUN;
    busy_d   = state_d != IDLE;
    a_done_d = state_d == DONE && !owner_q;
    b_done_d = state_d == DONE && owner_q;
    err_d    = state_d == DONE && abort;
  end

  // state and output registers, synchronous active-low reset discards any transfer
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      rw_q     <= 1'b0;
      idx_q    <= '0;
      size_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      rw_q     <= rw_d;
      idx_q    <= idx_d;
      size_q   <= size_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
      err_q    <= err_d;
    end
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign a_done      = a_done_q;
  assign b_done      = b_done_q;
  assign cntl_rw     = rw_q;
  assign cntl_index  = idx_q;
  assign cntl_size   = size_q;
  assign cntl_en     = en_q;
  assign busy        = busy_q;
  assign done_err    = err_q;
endmodule

// File: tb/tb_axis_bram_adapter_v1_0_sched.sv
// tb_axis_bram_adapter_v1_0_sched: directed plus random checks of the scheduler against a transfer-level reference
module tb_axis_bram_adapter_v1_0_sched;
`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif
  localparam int DEPTH = 512;
  logic clk = 1'b0, rstn;
  logic a_v, a_rdy, a_rw, a_dn, b_v, b_rdy, b_rw, b_dn;
  logic [8:0] a_idx, a_end, b_idx, b_end, c_idx, c_size;
  logic c_rw, c_en, beat, busy, derr;
  int total = 0, bad = 0;
  int stage = 0, len = 0, beats = 0, stall = 0;
  bit rr = 0, own = 0, m_rw = 0, m_err = 0, a_got = 0, b_got = 0;
  logic [8:0] m_idx = '0, m_end = '0;
  int grants[$];
  int en_cycles = 0, beat_cnt = 0, a_pulses = 0, b_pulses = 0, err_pulses = 0;

  always #5 clk = ~clk;

  axis_bram_adapter_v1_0_sched #(.ADDR_W(9), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .a_req_valid(a_v), .a_req_ready(a_rdy), .a_req_rw(a_rw), .a_req_index(a_idx), .a_req_end(a_end), .a_done(a_dn),
    .b_req_valid(b_v), .b_req_ready(b_rdy), .b_req_rw(b_rw), .b_req_index(b_idx), .b_req_end(b_end), .b_done(b_dn),
    .cntl_rw(c_rw), .cntl_index(c_idx), .cntl_size(c_size), .cntl_en(c_en),
    .bram_beat(beat), .busy(busy), .done_err(derr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int xfer_len(input logic [8:0] s, input logic [8:0] e);
    return ((int'(e) - int'(s)) % DEPTH + DEPTH) % DEPTH + 1;
  endfunction

  // one clock cycle: inputs already driven at the negedge; check, advance the reference, wait
  task automatic cyc();
    int win;
    #1;
    win = 0;
    if (rstn && stage == 0) win = (a_v && b_v) ? (rr ? 2 : 1) : a_v ? 1 : b_v ? 2 : 0;
    check("a_ready", a_rdy, win == 1);
    check("b_ready", b_rdy, win == 2);
    check("busy", busy, stage != 0);
    check("cntl_en", c_en, stage == 2);
    check("a_done", a_dn, stage == 3 && !own);
    check("b_done", b_dn, stage == 3 && own);
    check("done_err", derr, stage == 3 && m_err);
    check("cntl_rw", c_rw, m_rw);
    check("cntl_index", c_idx, m_idx);
    check("cntl_size", c_size, m_end);
    if (c_en === 1'b1) en_cycles++;
    if (c_en === 1'b1 && beat) beat_cnt++;
    if (a_dn === 1'b1) a_pulses++;
    if (b_dn === 1'b1) b_pulses++;
    if (derr === 1'b1) err_pulses++;
    a_got = win == 1;
    b_got = win == 2;
    if (win != 0) grants.push_back(win);
    if (!rstn) begin
      stage = 0; rr = 0; own = 0; m_rw = 0; m_idx = '0; m_end = '0; m_err = 0;
    end else if (stage == 0) begin
      if (win != 0) begin
        own = win == 2;
        m_rw = own ? b_rw : a_rw;
        m_idx = own ? b_idx : a_idx;
        m_end = own ? b_end : a_end;
        len = xfer_len(m_idx, m_end);
        if (a_v && b_v) rr = !rr;
        stage = 1;
      end
    end else if (stage == 1) begin
      stage = 2; beats = 0; stall = 0;
    end else if (stage == 2) begin
      if (beat) begin
        beats++; stall = 0;
        if (beats == len) begin stage = 3; m_err = 0; end
      end else begin
        stall++;
`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
        if (stall == TMO) begin stage = 3; m_err = 1; end
`endif
      end
    end else stage = 0;
    @(negedge clk);
  endtask

  task automatic clr_counts();
    en_cycles = 0; beat_cnt = 0; a_pulses = 0; b_pulses = 0; err_pulses = 0;
    grants.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (a_got) a_v = 0;
      if (b_got) b_v = 0;
    end
  endtask

  initial begin
    rstn = 0; a_v = 0; b_v = 0; a_rw = 0; b_rw = 0; beat = 0;
    a_idx = '0; a_end = '0; b_idx = '0; b_end = '0;
    @(posedge clk);
    @(negedge clk);
    cyc();
    rstn = 1;
    clr_counts();
    a_v = 1; a_rw = 1; a_idx = 9'd0; a_end = 9'd15; beat = 1;
    run(22);
    check("t1_en_cycles", en_cycles, 16);
    check("t1_a_done_pulses", a_pulses, 1);
    check("t1_err_pulses", err_pulses, 0);
    clr_counts();
    a_v = 1; a_rw = 1; a_idx = 9'd100; a_end = 9'd103;
    b_v = 1; b_rw = 0; b_idx = 9'd200; b_end = 9'd201;
    run(20);
    check("t2_grant_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("t2_first", grants[0], 1);
      check("t2_second", grants[1], 2);
    end
    clr_counts();
    a_v = 1; b_v = 1;
    run(20);
    check("t2b_grant_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("t2b_first", grants[0], 2);
      check("t2b_second", grants[1], 1);
    end
    clr_counts();
    b_v = 1; b_rw = 0; b_idx = 9'd6; b_end = 9'd15;
    for (int i = 0; i < 30; i++) begin
      beat = i[0];
      cyc();
      if (b_got) b_v = 0;
    end
    check("t3_beats", beat_cnt, 10);
    check("t3_b_done_pulses", b_pulses, 1);
    clr_counts();
    beat = 1; a_v = 1; a_idx = 9'd510; a_end = 9'd1;
    run(10);
    check("t4_wrap_en_cycles", en_cycles, 4);
    clr_counts();
    a_v = 1; a_idx = 9'd7; a_end = 9'd7;
    run(6);
    check("t4_equal_en_cycles", en_cycles, 1);
    check("t4_equal_done", a_pulses, 1);
    clr_counts();
    a_v = 1; a_idx = 9'd0; a_end = 9'd15;
    run(7);
    check("t5_beats_before_reset", beat_cnt, 5);
    rstn = 0;
    cyc();
    rstn = 1; beat = 0;
    clr_counts();
    run(4);
    check("t5_no_done", a_pulses + b_pulses, 0);
    check("t5_no_busy_cycles", en_cycles, 0);
`ifdef AXIS_BRAM_SCHED_TIMEOUT_EN
    clr_counts();
    beat = 1; a_v = 1; a_idx = 9'd0; a_end = 9'd15;
    run(5);
    beat = 0;
    run(12);
    check("t6_en_cycles", en_cycles, 11);
    check("t6_err_pulses", err_pulses, 1);
    check("t6_a_done_pulses", a_pulses, 1);
`endif
    for (int i = 0; i < 3000; i++) begin
      if (!a_v && $urandom_range(0, 3) == 0) begin
        a_v = 1; a_rw = 1'($urandom); a_idx = 9'($urandom);
        a_end = ($urandom_range(0, 7) == 0) ? 9'($urandom) : a_idx + 9'($urandom_range(0, 20));
      end else if (a_v && $urandom_range(0, 40) == 0) a_v = 0;
      if (!b_v && $urandom_range(0, 3) == 0) begin
        b_v = 1; b_rw = 1'($urandom); b_idx = 9'($urandom);
        b_end = ($urandom_range(0, 7) == 0) ? 9'($urandom) : b_idx + 9'($urandom_range(0, 20));
      end else if (b_v && $urandom_range(0, 40) == 0) b_v = 0;
      beat = $urandom_range(0, 3) != 0;
      rstn = $urandom_range(0, 600) != 0;
      cyc();
      if (a_got) a_v = 0;
      if (b_got) b_v = 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_bram_adapter_v1_0_sched.md
Name: axis_bram_adapter_v1_0_sched

Overview:
Two-requester scheduler in front of the AXIS/BRAM adapter controller. It shares the adapter's single BRAM port between two requesters: A (typically the stream-in/write side) and B (typically the stream-out/read side). Each request is a (rw, start index, end index) transfer command. The block arbitrates round-robin, loads the winning command into the controller's rw/index_cntl/size_cntl inputs, gates the controller on, counts BRAM beats, and returns a per-requester completion pulse.

Parameters:
ADDR_W, 9, BRAM word address width; matches the controller's index/size width.
TIMEOUT, 256, idle-beat cycles before abort; used only with the optional feature.

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset, sampled on rising clk
a_req_valid  in  1  requester A command valid
a_req_ready  out  1  requester A command accepted (1-cycle pulse)
a_req_rw  in  1  1 = write to BRAM, 0 = read from BRAM
a_req_index  in  ADDR_W  start address
a_req_end  in  ADDR_W  end address, inclusive
a_done  out  1  A transfer complete (1-cycle pulse)
b_req_valid, b_req_ready, b_req_rw, b_req_index, b_req_end, b_done  same as A, for requester B
cntl_rw  out  1  to controller rw
cntl_index  out  ADDR_W  to controller index_cntl
cntl_size  out  ADDR_W  to controller size_cntl (end address)
cntl_en  out  1  controller enable; controller holds idle when 0
bram_beat  in  1  controller's bram_en; one BRAM access per high cycle
busy  out  1  high in every state except IDLE
done_err  out  1  qualifies a_done/b_done: 1 = aborted

Behaviour:
- Reset (rstn=0 at a clk edge): state = IDLE; rr_ptr = A. All outputs are 0: a/b_req_ready, a/b_done, cntl_rw, cntl_index, cntl_size, cntl_en, busy, done_err. Beat counter = 0. A reset during LOAD/RUN/DONE discards the transfer and emits no done pulse.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - x_req_ready is combinational and goes high only for the winner.
  - Only one valid: that requester wins.
  - Both valid: the rr_ptr side wins, and rr_ptr flips to the other side.
  - On the ready&valid edge: latch rw/index/end/owner into the cntl_* registers and compute len = ((end - index) mod 2^ADDR_W) + 1. end < index wraps through address 2^ADDR_W-1 to 0; index == end gives len = 1.
  - Next state: LOAD.
- LOAD: exactly 1 cycle. cntl_rw/index/size are stable and cntl_en = 0 so the controller samples its configuration. busy = 1. Next state: RUN.
- RUN:
  - cntl_en = 1.
  - Beat counter increments on each bram_beat.
  - Counter reaching len (beat sampled in the cycle count == len-1) -> DONE; cntl_en drops to 0 on that same edge.
  - bram_beat is ignored outside RUN.
  - cntl_* registers hold for the whole transfer.
  - New requests wait with ready = 0; the requester must keep valid and its command stable.
- DONE: 1 cycle. Pulse owner's x_done = 1 with done_err = 0. Beat counter cleared. Next state: IDLE, so a pending request can be accepted in the following cycle (minimum 3 idle cycles between transfers: LOAD, DONE, plus the IDLE grant).
- Latency: grant edge -> cntl_en high 2 cycles later. Last beat -> x_done 1 cycle later.
- A request dropped (valid deasserted) before its grant is simply not serviced.

Optional Feature:
AXIS_BRAM_SCHED_TIMEOUT_EN.
- Defined: a watchdog counter clears on every bram_beat and on entry to RUN, and increments each RUN cycle without a beat. On reaching TIMEOUT it forces RUN -> DONE, dropping cntl_en. The owner's x_done pulses with done_err = 1.
- Not defined: there is no watchdog; RUN waits indefinitely for beats, and done_err is tied 0.

Test Plan:
- Reset, then A write index 0 end 15, bram_beat held 1 -> a_req_ready pulse; cntl_en high 16 cycles starting 2 cycles after grant; a_done pulses 1 cycle after the 16th beat; done_err = 0.
- A and B valid in the same cycle after reset -> A granted first; B granted in the IDLE cycle after a_done. Both valid again -> B wins, then A (rr alternation).
- B read index 6 end 15 with bram_beat toggling 1/0 -> exactly 10 beats counted, b_done after the 10th beat, cntl_index = 6 and cntl_size = 15 stable throughout.
- Wrap: A index 510 end 1 -> len 4. Equal: index 7 end 7 -> len 1, done after 1 beat.
- rstn = 0 for one cycle mid-RUN at beat 5 -> next cycle all outputs 0, state IDLE, no done pulse.
- With AXIS_BRAM_SCHED_TIMEOUT_EN and TIMEOUT = 8: stall bram_beat after 3 beats -> cntl_en drops after 8 beat-less cycles; x_done = 1 with done_err = 1.
